// File: rtl/ex_mem_skid_reg.sv
// EX/MEM boundary register with a two-entry skid buffer, forwarding tap and stall counter.
// in_ready depends only on flops, so a memory stall never reaches execute combinationally.
module ex_mem_skid_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_result,
  input  logic [3:0]       in_flags,
  input  logic [XLEN-1:0]  in_wdata,
  input  logic [XLEN-1:0]  in_pc4,
  input  logic [4:0]       in_rd,
  input  logic [3:0]       in_ctrl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [3:0]       out_flags,
  output logic [XLEN-1:0]  out_wdata,
  output logic [XLEN-1:0]  out_pc4,
  output logic [4:0]       out_rd,
  output logic [3:0]       out_ctrl,
  output logic             fwd_valid,
  output logic [4:0]       fwd_rd,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [3:0]      flags;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] pc4;
    logic [4:0]      rd;
    logic [3:0]      ctrl;
  } entry_t;

  // State encodes both valid bits: BUSY = main only, FULL = main and skid.
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t           r_state, w_state_nxt;
  entry_t           r_main, r_skid, w_in;
  logic [CNT_W-1:0] r_stall;
  logic             w_accept, w_deliver;
  logic             w_ld_main_in, w_ld_main_skid, w_ld_skid;

  assign w_in      = '{result: in_result, flags: in_flags, wdata: in_wdata,
                       pc4: in_pc4, rd: in_rd, ctrl: in_ctrl};
  assign in_ready  = (r_state != FULL);
  assign out_valid = (r_state != EMPTY);
  assign w_accept  = in_valid & in_ready;
  assign w_deliver = out_valid & out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= EMPTY;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    w_ld_skid      = 1'b0;
    if (flush) begin
      w_state_nxt = EMPTY;
    end else begin
      unique case (r_state)
        EMPTY: if (w_accept) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = BUSY;
        end
        BUSY: begin
          if (w_deliver && w_accept) begin
            w_ld_main_in = 1'b1;
          end else if (w_deliver) begin
            w_state_nxt = EMPTY;
          end else if (w_accept) begin
            w_ld_skid   = 1'b1;
            w_state_nxt = FULL;
          end
        end
        FULL: if (w_deliver) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = BUSY;
        end
        default: w_state_nxt = EMPTY;
      endcase
    end
  end

  // Payload is not cleared on flush; the valid state masks stale data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      if (w_ld_main_in)        r_main <= w_in;
      else if (w_ld_main_skid) r_main <= r_skid;
      if (w_ld_skid)           r_skid <= w_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_stall <= '0;
    else if (out_valid && !out_ready && (r_stall != {CNT_W{1'b1}}))
      r_stall <= r_stall + CNT_W'(1);
  end

  assign out_result = r_main.result;
  assign out_flags  = r_main.flags;
  assign out_wdata  = r_main.wdata;
  assign out_pc4    = r_main.pc4;
  assign out_rd     = r_main.rd;
  assign out_ctrl   = r_main.ctrl;
  assign fwd_valid  = out_valid & r_main.ctrl[3] & (r_main.rd != 5'd0);
  assign fwd_rd     = r_main.rd;
  assign fwd_data   = r_main.result;
  assign stall_cnt  = r_stall;

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Bench for ex_mem_skid_reg: directed table, hand corner sequences, random run vs a queue model.
module tb_ex_mem_skid_reg;
  logic        clk = 1'b0, reset = 1'b1, flush = 1'b0;
  logic        in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_result = '0, in_wdata = '0, in_pc4 = '0;
  logic [3:0]  in_flags = '0, in_ctrl = '0;
  logic [4:0]  in_rd = '0;

  logic        in_ready, out_valid, fwd_valid;
  logic [31:0] out_result, out_wdata, out_pc4, fwd_data;
  logic [3:0]  out_flags, out_ctrl;
  logic [4:0]  out_rd, fwd_rd;
  logic [15:0] stall_cnt;

  logic        s_in_ready, s_out_valid, s_fwd_valid;
  logic [31:0] s_out_result, s_out_wdata, s_out_pc4, s_fwd_data;
  logic [3:0]  s_out_flags, s_out_ctrl;
  logic [4:0]  s_out_rd, s_fwd_rd;
  logic [3:0]  s_stall_cnt;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_skid_reg #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_wdata(in_wdata), .in_pc4(in_pc4),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_flags(out_flags), .out_wdata(out_wdata), .out_pc4(out_pc4),
    .out_rd(out_rd), .out_ctrl(out_ctrl), .fwd_valid(fwd_valid), .fwd_rd(fwd_rd),
    .fwd_data(fwd_data), .stall_cnt(stall_cnt));

  ex_mem_skid_reg #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_result(in_result), .in_flags(in_flags), .in_wdata(in_wdata), .in_pc4(in_pc4),
    .in_rd(in_rd), .in_ctrl(in_ctrl), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_result(s_out_result), .out_flags(s_out_flags), .out_wdata(s_out_wdata),
    .out_pc4(s_out_pc4), .out_rd(s_out_rd), .out_ctrl(s_out_ctrl), .fwd_valid(s_fwd_valid),
    .fwd_rd(s_fwd_rd), .fwd_data(s_fwd_data), .stall_cnt(s_stall_cnt));

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        vin;
    logic [31:0] res;
    logic        ordy;
    logic        exp_ov;
    logic [31:0] exp_res;
    logic        exp_ir;
    logic [15:0] exp_stall;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic [3:0]  flags;
    logic [31:0] wdata;
    logic [31:0] pc4;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } ent_t;

  vec_t vt[10];
  ent_t q[$];
  ent_t e;
  int   m_stall;
  bit   m_ir, m_ov;

  initial begin
    // streaming, then backpressure with A/B/C
    vt[0] = '{1'b1, 32'h1,        1'b1, 1'b1, 32'h1,        1'b1, 16'd0};
    vt[1] = '{1'b1, 32'h2,        1'b1, 1'b1, 32'h2,        1'b1, 16'd0};
    vt[2] = '{1'b1, 32'h3,        1'b1, 1'b1, 32'h3,        1'b1, 16'd0};
    vt[3] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 16'd0};
    vt[4] = '{1'b1, 32'hAAAA0000, 1'b0, 1'b1, 32'hAAAA0000, 1'b1, 16'd0};
    vt[5] = '{1'b1, 32'h5555FFFF, 1'b0, 1'b1, 32'hAAAA0000, 1'b0, 16'd1};
    vt[6] = '{1'b1, 32'hC0C0C0C0, 1'b0, 1'b1, 32'hAAAA0000, 1'b0, 16'd2};
    vt[7] = '{1'b1, 32'hC0C0C0C0, 1'b1, 1'b1, 32'h5555FFFF, 1'b1, 16'd2};
    vt[8] = '{1'b1, 32'hC0C0C0C0, 1'b1, 1'b1, 32'hC0C0C0C0, 1'b1, 16'd2};
    vt[9] = '{1'b0, 32'h0,        1'b1, 1'b0, 32'h0,        1'b1, 16'd2};

    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready",  in_ready,  1);
    chk("rst_result",    out_result, 0);
    chk("rst_fwd_valid", fwd_valid, 0);
    chk("rst_stall",     stall_cnt, 0);
    #4 reset = 1'b0;
    step();

    in_ctrl = 4'b0000; in_rd = 5'd1;
    for (int i = 0; i < 10; i++) begin
      in_valid = vt[i].vin; in_result = vt[i].res; out_ready = vt[i].ordy;
      step();
      chk($sformatf("vec%0d_out_valid", i), out_valid, vt[i].exp_ov);
      if (vt[i].exp_ov) chk($sformatf("vec%0d_result", i), out_result, vt[i].exp_res);
      chk($sformatf("vec%0d_in_ready", i), in_ready, vt[i].exp_ir);
      chk($sformatf("vec%0d_stall", i), stall_cnt, vt[i].exp_stall);
    end

    // flush while FULL with a simultaneous input
    out_ready = 1'b0; in_valid = 1'b1; in_result = 32'h11; step();
    in_result = 32'h22; step();
    chk("fl_full_in_ready", in_ready, 0);
    flush = 1'b1; in_result = 32'h33; step();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready",  in_ready, 1);
    chk("fl_fwd_valid", fwd_valid, 0);
    flush = 1'b0; in_valid = 1'b0; step();
    chk("fl_dropped", out_valid, 0);

    // forwarding tap and flag passthrough
    out_ready = 1'b1; in_valid = 1'b1;
    in_rd = 5'd5; in_ctrl = 4'b1000; in_result = 32'hDEADBEEF; step();
    chk("fwd_valid_rd5", fwd_valid, 1);
    chk("fwd_data",      fwd_data, 32'hDEADBEEF);
    chk("fwd_rd",        fwd_rd, 5);
    in_rd = 5'd0; step();
    chk("fwd_valid_rd0", fwd_valid, 0);
    in_rd = 5'd5; in_ctrl = 4'b0000; step();
    chk("fwd_valid_nowr", fwd_valid, 0);
    in_ctrl = 4'b1000; in_rd = 5'd3; in_flags = 4'b1010; in_result = 32'h80000000; step();
    chk("flags_pass",  out_flags, 4'b1010);
    chk("flags_result", out_result, 32'h80000000);
    in_valid = 1'b0; in_flags = 4'b0000; step();

    // asynchronous reset while FULL
    out_ready = 1'b0; in_valid = 1'b1; step(); step();
    chk("ar_full", in_ready, 0);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_out_valid", out_valid, 0);
    chk("ar_stall",     stall_cnt, 0);
    chk("ar_in_ready",  in_ready, 1);
    chk("ar_result",    out_result, 0);
    chk("ar_fwd_valid", fwd_valid, 0);
    #2 reset = 1'b0;

    // saturation of the narrow counter
    in_valid = 1'b1; step();
    in_valid = 1'b0;
    repeat (20) step();
    chk("sat_cnt4",  s_stall_cnt, 4'd15);
    chk("sat_cnt16", stall_cnt, 16'd20);

    // random run against a depth-2 FIFO model
    #2 reset = 1'b1; #4 reset = 1'b0;
    q.delete(); m_stall = 0;
    for (int c = 0; c < 400; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 6);
      flush     = ($urandom_range(0, 15) == 0);
      e.result = $urandom; e.flags = 4'($urandom); e.wdata = $urandom;
      e.pc4 = $urandom; e.rd = 5'($urandom); e.ctrl = 4'($urandom);
      in_result = e.result; in_flags = e.flags; in_wdata = e.wdata;
      in_pc4 = e.pc4; in_rd = e.rd; in_ctrl = e.ctrl;
      m_ir = (q.size() < 2);
      m_ov = (q.size() > 0);
      if (m_ov && !out_ready && m_stall < 65535) m_stall++;
      if (flush) q.delete();
      else begin
        if (m_ov && out_ready) void'(q.pop_front());
        if (in_valid && m_ir) q.push_back(e);
      end
      step();
      flush = 1'b0;
      chk("rnd_out_valid", out_valid, q.size() > 0);
      chk("rnd_in_ready",  in_ready,  q.size() < 2);
      chk("rnd_stall",     stall_cnt, m_stall);
      if (q.size() > 0) begin
        chk("rnd_result", out_result, q[0].result);
        chk("rnd_flags",  out_flags,  q[0].flags);
        chk("rnd_wdata",  out_wdata,  q[0].wdata);
        chk("rnd_pc4",    out_pc4,    q[0].pc4);
        chk("rnd_rd",     out_rd,     q[0].rd);
        chk("rnd_ctrl",   out_ctrl,   q[0].ctrl);
        chk("rnd_fwd_valid", fwd_valid, q[0].ctrl[3] && q[0].rd != 0);
        chk("rnd_fwd_data",  fwd_data,  q[0].result);
      end else begin
        chk("rnd_fwd_idle", fwd_valid, 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_mem_skid_reg.md
Name: ex_mem_skid_reg

Overview:
- Execute-to-memory pipeline boundary register placed directly downstream of the ALU.
- Captures the ALU result, the ALU status flags (zero/negative/carry/overflow), the store data and the control bits for each instruction.
- Presents them to the memory stage through a valid/ready handshake.
- Has a two-entry skid buffer so a memory-stage stall never combinationally back-propagates into execute.
- Also exports a forwarding tap for the execute-stage operand muxes and a saturating stall counter.

Parameters:
- XLEN, 32, datapath width of result, store data and PC+4.
- CNT_W, 16, width of the stall counter.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous kill of all held entries (branch mispredict/trap).
- in_valid  in  1  execute stage presents an instruction.
- in_ready  out  1  register can accept; driven from a flop.
- in_result  in  XLEN  ALU result.
- in_flags  in  4  {overflow, carry, negative, zero} from the ALU.
- in_wdata  in  XLEN  store data (rs2 after forwarding).
- in_pc4  in  XLEN  PC+4 for jal/jalr writeback.
- in_rd  in  5  destination register.
- in_ctrl  in  4  {reg_write, mem_write, result_src[1:0]}.
- out_valid  out  1  entry available to memory stage.
- out_ready  in  1  memory stage accepts.
- out_result, out_flags, out_wdata, out_pc4, out_rd, out_ctrl  out  as above  head entry fields.
- fwd_valid  out  1  head entry writes a nonzero rd (out_valid & reg_write & rd!=0).
- fwd_rd  out  5  equals out_rd.
- fwd_data  out  XLEN  equals out_result.
- stall_cnt  out  CNT_W  cycles with out_valid & !out_ready, saturating.

Behaviour:
- Storage: a main entry (drives the out_* ports) and a skid entry, each with its own valid bit. The payload is 2*XLEN+XLEN+4+5+4 bits.
- Accept: occurs when in_valid & in_ready. Deliver: occurs when out_valid & out_ready.
- States and per-cycle updates:
  - EMPTY (neither valid): accept loads main → BUSY.
  - BUSY (main valid only):
    - Deliver with accept: main reloads from the input, stays BUSY.
    - Deliver without accept: → EMPTY.
    - Accept without deliver: input goes to skid → FULL.
    - Neither: hold.
  - FULL (both valid): in_ready=0, so no accept.
    - Deliver: skid moves to main, skid invalid → BUSY.
    - No deliver: hold.
- in_ready = !skid_valid, computed from flops only. There is no combinational path from out_ready to in_ready.
- out_* payload and out_valid come from flops. Latency from accept into EMPTY to out_valid is 1 cycle.
- Ordering: strictly FIFO; the skid entry is never delivered before main.
- Flush: has priority over every event in the same cycle.
  - Both valid bits clear on the next edge and the input is dropped even if accepted.
  - Payload flops may keep stale data, but out_valid=0 and fwd_valid=0.
  - Cycle after flush: EMPTY, in_ready=1.
- Forwarding tap: purely combinational from main-entry flops. fwd_valid is forced 0 when rd==0 or reg_write==0.
- stall_cnt: increments by 1 each cycle with out_valid & !out_ready, saturates at all-ones, and is not cleared by flush.
- Reset (asynchronous, any time including mid-transfer):
  - Both valids=0 and in_ready=1.
  - All payload outputs=0, fwd_valid=0, stall_cnt=0.
  - After reset deasserts, the first edge behaves as EMPTY.
- Flags and results are passed bit-exact. No arithmetic is performed on the payload.

Test Plan:
- Streaming with out_ready=1: feed results 0x1, 0x2, 0x3 on consecutive cycles. Required: out_result 0x1, 0x2, 0x3 one cycle later each; in_ready stays 1; stall_cnt=0.
- Backpressure: out_ready=0, feed A=0xAAAA0000 then B=0x5555FFFF.
  - Required: after B, in_ready=0 and out_result=A; C held on input is not accepted.
  - Raise out_ready: A, then B, then C delivered in order; stall_cnt equals the stalled cycles.
- Flush while FULL, with in_valid=1 that same cycle. Required: next cycle out_valid=0, in_ready=1; the new input is discarded.
- Forwarding: entry rd=5, reg_write=1, result 0xDEADBEEF → fwd_valid=1, fwd_data=0xDEADBEEF. Same with rd=0 → fwd_valid=0. Same with reg_write=0 → fwd_valid=0.
- Flags passthrough: in_flags=4'b1010 (overflow, negative) with a sub result of 0x80000000 → out_flags=4'b1010 unchanged.
- Asynchronous reset asserted mid-cycle while FULL. Required: out_valid=0 and stall_cnt=0 immediately, without waiting for an edge; in_ready=1; CNT_W=4 saturation test holds at 15.
